// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start bit, data MSB-first, even parity, stop bit.
// Every bit is held on x for CLKS_PER_BIT cycles; x is registered.
module serial_bit_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              x
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               done_q, done_d;
    logic               x_q, x_d;
    logic               bit_end;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        bit_end  = (cyc_q == CYC_LAST);

        if (state_q != StIdle) begin
            cyc_d = bit_end ? '0 : cyc_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                cyc_d = '0;
                bit_d = '0;
                if (start) begin
                    shift_d  = data_in;
                    parity_d = ^data_in;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = StParity;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is derived from the next state so x lines up with the state register.
        case (state_d)
            StStart:  x_d = 1'b1;
            StData:   x_d = shift_d[DATA_W-1];
            StParity: x_d = parity_d;
            default:  x_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            x_q      <= x_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = ~ready;
    assign done  = done_q;
    assign x     = x_q;

endmodule

// File: doc/serial_bit_tx.md
# serial_bit_tx

Serial frame transmitter that drives the single-bit `x` line consumed by the serial receive/detect blocks in the basics area. It accepts a parallel word with a start/ready handshake, then serialises it as a framed bit stream: start bit, data MSB-first, even-parity bit, stop bit. Each bit is held for a fixed number of clock cycles. The block is the transmit-side counterpart used to generate `x` stimulus in-system instead of from a bench.

## Interface
- `DATA_W`, 8, data bits per frame (≥1)
- `CLKS_PER_BIT`, 6, clock cycles each bit is held on `x` (≥1)

- `clk`  input  1  single clock; all state changes on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `data_in`  input  DATA_W  word to send; sampled only on an accepted `start`
- `start`  input  1  request to send; accepted when `start && ready` at a rising edge
- `ready`  output  1  high when in IDLE; decoded from the state register only
- `busy`  output  1  equals `~ready`
- `done`  output  1  one-cycle pulse when the stop bit completes
- `x`  output  1  serial line; registered

## Operation
- Line levels:
  - Idle = 0.
  - Start bit = 1.
  - Stop bit = 0.
  - Parity = XOR of all `DATA_W` data bits (even parity).
- States:
  - **IDLE**: `x`=0. An accepted start latches `data_in` into the shift register, computes parity from the latched value, and moves to START.
  - **START**: `x`=1 for `CLKS_PER_BIT` cycles, then DATA.
  - **DATA**: `x` = current MSB of the shift register. After each `CLKS_PER_BIT` cycles, shift left by one. After `DATA_W` bits, move to PARITY.
  - **PARITY**: `x` = parity for `CLKS_PER_BIT` cycles, then STOP.
  - **STOP**: `x`=0 for `CLKS_PER_BIT` cycles, then IDLE with `done`=1 for that cycle.
- Counters:
  - Cycle counter: width `$clog2(CLKS_PER_BIT)` (minimum 1). Counts 0 to `CLKS_PER_BIT-1`, then wraps to 0 at each bit boundary.
  - Bit counter: width `$clog2(DATA_W)` (minimum 1). Counts DATA bits 0 to `DATA_W-1`.
- `start` while busy is ignored and not queued. `data_in` changes while busy have no effect on the frame in flight.
- Back-to-back frames: in the IDLE cycle where `done`=1, `ready`=1. A `start` in that cycle is accepted, so the next start bit follows with no extra idle cycle beyond that one.
- `CLKS_PER_BIT`=1 is legal: each bit lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, `x`=0, `done`=0, `ready`=1, `busy`=0, counters=0, shift register=0.
- Reset mid-frame: on the next edge the state is IDLE, `x`=0, and no `done` pulse is produced. A `start` asserted together with `rst` is ignored.
- Accept at edge E0. `x` shows the start bit from E0 for `CLKS_PER_BIT` cycles.
- Data bit k (k=0 is the MSB) starts at E0 + (1+k)·`CLKS_PER_BIT`.
- Parity starts at E0 + (1+`DATA_W`)·`CLKS_PER_BIT`.
- Stop starts at E0 + (2+`DATA_W`)·`CLKS_PER_BIT`.
- At E0 + (3+`DATA_W`)·`CLKS_PER_BIT`: state returns to IDLE, `done`=1 for one cycle, `ready` rises.
- Total frame = (`DATA_W`+3)·`CLKS_PER_BIT` cycles; with defaults, 66 cycles.
- `busy` is high from E0 through the last stop-bit cycle.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `start`=1 → `x`=0, `ready`=1, `busy`=0, `done`=0 throughout; no frame starts.
- **Basic frame (defaults):** `data_in`=8'hA5, one-cycle `start` → `x` over 6-cycle bits = 1 | 1,0,1,0,0,1,0,1 | 0 (parity) | 0 (stop). `done` pulses exactly 66 cycles after accept.
- **Odd parity data:** `data_in`=8'h07 → data bits 0,0,0,0,0,1,1,1, then parity bit = 1. Change `data_in` to 8'hFF mid-frame → transmitted bits unchanged.
- **Ignored start:** pulse `start` with 8'h3C at cycle 20 of an 8'hA5 frame → no effect. Exactly one `done`, at cycle 66.
- **Back-to-back:** hold `start`=1 continuously with 8'h81 → second start bit begins the cycle after `done`. Frames repeat every 67 cycles, with one idle cycle at `x`=0 between them.
- **Reset mid-frame and `CLKS_PER_BIT`=1:**
  - Assert `rst` during the DATA state → `x`=0 and `ready`=1 next cycle; no `done`. A new frame then transmits normally.
  - With `CLKS_PER_BIT`=1 and `DATA_W`=4, 4'hB → `x` = 1,1,0,1,1,1,0 on consecutive cycles (start, data 1011, parity 1, stop 0). `done` arrives 7 cycles after accept.
